pc_fetch_gen: RTL and testbench
===============================

Name: pc_fetch_gen

Overview:
- Parametrised successor to the single-issue PC register in the fetch stage of the MIPS core.
- Generates the fetch PC for a fetch bundle of FETCH_WIDTH instructions, with a per-slot valid mask.
- Buffers a branch redirect that arrives while the pipeline is stalled, and applies it once the stall clears.
- Produces the IF-stage exception_type word: address error, TLB refill, TLB invalid.

Parameters:
- RESET_PC, 32'hBFC0_0000, PC value loaded on reset.
- FETCH_WIDTH, 1, instructions per fetch bundle; legal values 1, 2, 4. FETCH_BYTES = 4*FETCH_WIDTH.
- STALL_W, 4, width of the stall vector.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high (reset rst, synchronous, active-high; clock clk)
- stall  in  STALL_W  pipeline stall vector; any nonzero bit = stalled
- exception  in  1  exception redirect request
- exception_pc  in  32  exception handler target
- branch  in  1  branch redirect request
- branch_pc  in  32  branch target
- inst_paddr_refill  in  1  ITLB refill for current pc
- inst_paddr_invalid  in  1  ITLB invalid for current pc
- pc  out  32  current fetch address (registered)
- fetch_valid  out  FETCH_WIDTH  per-slot valid mask for the bundle at pc
- exception_type  out  32  {1'b0, adel, refill, invalid, 28'b0}
- redirect_pending  out  1  a buffered branch is waiting

Behaviour:
- Reset: pc = RESET_PC, state = RUN, pend_pc = 0, redirect_pending = 0. Reset has priority over every other input, including mid-PEND.
- States:
  - RUN: no buffered redirect.
  - PEND: pend_pc holds a branch target.
- Priority per cycle: rst > exception > branch > pending > sequential.
- exception = 1:
  - pc <= exception_pc regardless of stall.
  - state <= RUN; any pending branch is discarded.
- branch = 1, stall == 0: pc <= branch_pc; state <= RUN. A newer branch also overrides the pending one.
- branch = 1, stall != 0: pc holds; pend_pc <= branch_pc; state <= PEND. Overwrites an older pending target.
- PEND, branch = 0, stall == 0: pc <= pend_pc; state <= RUN.
- PEND, stall != 0, no new branch: everything holds.
- RUN, no request, stall == 0: pc <= (pc & ~(FETCH_BYTES-1)) + FETCH_BYTES. This is the next aligned bundle and wraps modulo 2^32. For FETCH_WIDTH = 1 it reduces to (pc & ~3) + 4.
- RUN, no request, stall != 0: pc holds.
- Redirect latency: one cycle from request edge to new pc, or from the stall-clear cycle to pend_pc.
- adel = (pc[1:0] != 0). Purely combinational from pc.
- fetch_valid[i] = !adel && (i >= pc[log2(FETCH_BYTES)-1:2]). With FETCH_WIDTH = 1, fetch_valid = !adel.
- exception_type is combinational from pc and the TLB inputs. Bit 30 = adel, bit 29 = refill, bit 28 = invalid, all other bits 0.
- redirect_pending = (state == PEND), registered.

Optional Feature:
- Macro: PC_REDIRECT_CNT_EN.
- When defined, adds outputs:
  - br_redirect_cnt (32): increments on each cycle pc is loaded from branch_pc or pend_pc.
  - exc_redirect_cnt (32): increments on each exception load.
  - Both counters reset to 0, wrap at 2^32, and are for performance testing.
- When undefined, these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package/header holds:
  - RST_ENABLE.
  - Exception bit positions EXC_ADEL_BIT = 30, EXC_REFILL_BIT = 29, EXC_INVALID_BIT = 28.
  - State encodings PC_ST_RUN = 1'b0, PC_ST_PEND = 1'b1.
  - Default RESET_PC.
- Sub-module pc_redirect_buf: PEND state plus pend_pc register, with inputs branch/branch_pc/stall/exception/rst and outputs pend_valid/pend_pc.
- The top level implements the PC mux, the mask and the exception word.

Test Plan:
- Reset, FETCH_WIDTH = 2, stall = 0 for 3 cycles -> pc = BFC00000, BFC00008, BFC00010; fetch_valid = 2'b11.
- FETCH_WIDTH = 2, branch_pc = 80000004 with stall = 0 -> next pc = 80000004, fetch_valid = 2'b10. Following cycle -> pc = 80000008, fetch_valid = 2'b11.
- Branch to 80001000 while stall = 4'b0010 for 3 cycles:
  - pc holds throughout; redirect_pending = 1.
  - Stall clears -> pc = 80001000 next cycle; redirect_pending = 0.
- PEND holding 80001000, exception with exception_pc = BFC00380 while stalled -> pc = BFC00380 next cycle; pending discarded; after the stall clears, pc continues sequentially from BFC00380.
- branch_pc = 80000002 -> pc = 80000002; exception_type = 32'h40000000; fetch_valid = 0. Additionally asserting inst_paddr_refill -> exception_type = 32'h60000000.
- pc = FFFFFFF8, FETCH_WIDTH = 2, stall = 0 -> pc wraps to 00000000. With PC_REDIRECT_CNT_EN defined, after 2 branches and 1 exception -> br_redirect_cnt = 2, exc_redirect_cnt = 1.

Source files
------------

// File: rtl/pc_fetch_gen_pkg.sv
// Shared constants for the fetch PC generator: reset level, exception word
// bit positions, redirect-buffer state encoding and the default boot vector.
package pc_fetch_gen_pkg;
    localparam logic RST_ENABLE = 1'b1;

    localparam int EXC_ADEL_BIT    = 30;
    localparam int EXC_REFILL_BIT  = 29;
    localparam int EXC_INVALID_BIT = 28;

    typedef enum logic {
        PC_ST_RUN  = 1'b0,
        PC_ST_PEND = 1'b1
    } pc_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'hBFC0_0000;
endpackage

// File: rtl/pc_fetch_gen_redirect_buf.sv
// Holds a branch target that arrived while the pipeline was stalled until the
// stall clears; an exception or a newer unstalled branch discards it.
module pc_redirect_buf
    import pc_fetch_gen_pkg::*;
#(
    parameter int STALL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               exception,
    input  logic               branch,
    input  logic [31:0]        branch_pc,
    output logic               pend_valid,
    output logic [31:0]        pend_pc
);
    pc_state_e   state, state_nxt;
    logic [31:0] pend_pc_nxt;
    logic        stalled;

    assign stalled = |stall;

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state   <= PC_ST_RUN;
            pend_pc <= 32'h0;
        end else begin
            state   <= state_nxt;
            pend_pc <= pend_pc_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pend_pc_nxt = pend_pc;
        if (exception) begin
            state_nxt = PC_ST_RUN;
        end else if (branch) begin
            // A stalled branch parks (replacing any older target); an unstalled one is taken directly.
            if (stalled) begin
                state_nxt   = PC_ST_PEND;
                pend_pc_nxt = branch_pc;
            end else begin
                state_nxt = PC_ST_RUN;
            end
        end else if (state == PC_ST_PEND && !stalled) begin
            state_nxt = PC_ST_RUN;
        end
    end

    assign pend_valid = (state == PC_ST_PEND);
endmodule

// File: rtl/pc_fetch_gen.sv
// Fetch-stage PC generator for FETCH_WIDTH-wide bundles with stalled-branch
// buffering. Define PC_REDIRECT_CNT_EN to add branch/exception redirect counters.
module pc_fetch_gen
    import pc_fetch_gen_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter int          FETCH_WIDTH = 1,
    parameter int          STALL_W     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [STALL_W-1:0]     stall,
    input  logic                   exception,
    input  logic [31:0]            exception_pc,
    input  logic                   branch,
    input  logic [31:0]            branch_pc,
    input  logic                   inst_paddr_refill,
    input  logic                   inst_paddr_invalid,
    output logic [31:0]            pc,
    output logic [FETCH_WIDTH-1:0] fetch_valid,
    output logic [31:0]            exception_type,
    output logic                   redirect_pending
`ifdef PC_REDIRECT_CNT_EN
    ,
    output logic [31:0]            br_redirect_cnt,
    output logic [31:0]            exc_redirect_cnt
`endif
);
    localparam int          FETCH_BYTES = 4 * FETCH_WIDTH;
    localparam logic [31:0] BUNDLE_MASK = ~(32'(FETCH_BYTES) - 32'd1);

    logic        stalled, pend_valid, adel;
    logic [31:0] pend_pc, pc_nxt;

    assign stalled = |stall;

    pc_redirect_buf #(.STALL_W(STALL_W)) u_redirect_buf (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .exception  (exception),
        .branch     (branch),
        .branch_pc  (branch_pc),
        .pend_valid (pend_valid),
        .pend_pc    (pend_pc)
    );

    always_comb begin
        pc_nxt = pc;
        if (exception)
            pc_nxt = exception_pc;
        else if (branch)
            pc_nxt = stalled ? pc : branch_pc;
        else if (pend_valid && !stalled)
            pc_nxt = pend_pc;
        else if (!stalled)
            pc_nxt = (pc & BUNDLE_MASK) + 32'(FETCH_BYTES);
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE)
            pc <= RESET_PC;
        else
            pc <= pc_nxt;
    end

    assign redirect_pending = pend_valid;
    assign adel = (pc[1:0] != 2'b00);

    always_comb begin
        exception_type                  = 32'h0;
        exception_type[EXC_ADEL_BIT]    = adel;
        exception_type[EXC_REFILL_BIT]  = inst_paddr_refill;
        exception_type[EXC_INVALID_BIT] = inst_paddr_invalid;
    end

    // Slots before the entry word of the bundle (branch into mid-bundle) are masked off.
    if (FETCH_WIDTH == 1) begin : g_single
        assign fetch_valid = !adel;
    end else begin : g_multi
        localparam int SLOT_W = $clog2(FETCH_WIDTH);
        logic [SLOT_W-1:0] slot;
        assign slot = pc[SLOT_W+1:2];
        for (genvar i = 0; i < FETCH_WIDTH; i++) begin : g_slot
            assign fetch_valid[i] = !adel && (SLOT_W'(i) >= slot);
        end
    end

`ifdef PC_REDIRECT_CNT_EN
    logic br_load;
    assign br_load = !exception && ((branch && !stalled) || (!branch && pend_valid && !stalled));

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            br_redirect_cnt  <= 32'h0;
            exc_redirect_cnt <= 32'h0;
        end else begin
            if (br_load)
                br_redirect_cnt <= br_redirect_cnt + 32'd1;
            if (exception)
                exc_redirect_cnt <= exc_redirect_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_pc_fetch_gen.sv
// Directed vector bench for pc_fetch_gen at FETCH_WIDTH = 2.
module tb_pc_fetch_gen;
    localparam int FW = 2;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [SW-1:0] stall;
    logic          exception, branch, refill, invalid;
    logic [31:0]   exception_pc, branch_pc;
    logic [31:0]   pc, exception_type;
    logic [FW-1:0] fetch_valid;
    logic          redirect_pending;
`ifdef PC_REDIRECT_CNT_EN
    logic [31:0]   br_cnt, exc_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pc_fetch_gen #(.RESET_PC(32'hBFC0_0000), .FETCH_WIDTH(FW), .STALL_W(SW)) dut (
        .clk                (clk),
        .rst                (rst),
        .stall              (stall),
        .exception          (exception),
        .exception_pc       (exception_pc),
        .branch             (branch),
        .branch_pc          (branch_pc),
        .inst_paddr_refill  (refill),
        .inst_paddr_invalid (invalid),
        .pc                 (pc),
        .fetch_valid        (fetch_valid),
        .exception_type     (exception_type),
        .redirect_pending   (redirect_pending)
`ifdef PC_REDIRECT_CNT_EN
        ,
        .br_redirect_cnt    (br_cnt),
        .exc_redirect_cnt   (exc_cnt)
`endif
    );

    typedef struct {
        logic [SW-1:0] stall;
        logic          exc;
        logic [31:0]   exc_pc;
        logic          br;
        logic [31:0]   br_pc;
        logic          refill;
        logic          invalid;
        logic [31:0]   e_pc;
        logic [FW-1:0] e_valid;
        logic [31:0]   e_etype;
        logic          e_pend;
    } vec_t;

    localparam int NV = 30;
    vec_t vecs[NV];

    function automatic vec_t mk(logic [SW-1:0] st, logic ex, logic [31:0] expc, logic b,
                                logic [31:0] bpc, logic rf, logic iv, logic [31:0] epc,
                                logic [FW-1:0] ev, logic [31:0] et, logic ep);
        vec_t v;
        v.stall = st; v.exc = ex; v.exc_pc = expc; v.br = b; v.br_pc = bpc;
        v.refill = rf; v.invalid = iv;
        v.e_pc = epc; v.e_valid = ev; v.e_etype = et; v.e_pend = ep;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [SW-1:0] st, input logic ex, input logic [31:0] expc,
                         input logic b, input logic [31:0] bpc, input logic rf, input logic iv);
        stall = st; exception = ex; exception_pc = expc; branch = b; branch_pc = bpc;
        refill = rf; invalid = iv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // stall, exc, exc_pc, br, br_pc, refill, invalid, exp pc, exp valid, exp etype, exp pend
        vecs[0]  = mk(4'h0, 0, 0, 0, 0,            0, 0, 32'hBFC00008, 2'b11, 32'h0, 0);
        vecs[1]  = mk(4'h0, 0, 0, 0, 0,            0, 0, 32'hBFC00010, 2'b11, 32'h0, 0);
        vecs[2]  = mk(4'h0, 0, 0, 0, 0,            0, 0, 32'hBFC00018, 2'b11, 32'h0, 0);
        vecs[3]  = mk(4'h0, 0, 0, 1, 32'h80000004, 0, 0, 32'h80000004, 2'b10, 32'h0, 0);
        vecs[4]  = mk(4'h0, 0, 0, 0, 0,            0, 0, 32'h80000008, 2'b11, 32'h0, 0);
        vecs[5]  = mk(4'h2, 0, 0, 1, 32'h80001000, 0, 0, 32'h80000008, 2'b11, 32'h0, 1);
        vecs[6]  = mk(4'h2, 0, 0, 0, 0,            0, 0, 32'h80000008, 2'b11, 32'h0, 1);
        vecs[7]  = mk(4'h2, 0, 0, 0, 0,            0, 0, 32'h80000008, 2'b11, 32'h0, 1);
        vecs[8]  = mk(4'h0, 0, 0, 0, 0,            0, 0, 32'h80001000, 2'b11, 32'h0, 0);
        vecs[9]  = mk(4'h4, 0, 0, 1, 32'h80002000, 0, 0, 32'h80001000, 2'b11, 32'h0, 1);
        vecs[10] = mk(4'h4, 1, 32'hBFC00380, 0, 0, 0, 0, 32'hBFC00380, 2'b11, 32'h0, 0);
        vecs[11] = mk(4'h4, 0, 0, 0, 0,            0, 0, 32'hBFC00380, 2'b11, 32'h0, 0);
        vecs[12] = mk(4'h0, 0, 0, 0, 0,            0, 0, 32'hBFC00388, 2'b11, 32'h0, 0);
        vecs[13] = mk(4'h0, 0, 0, 1, 32'h80000002, 0, 0, 32'h80000002, 2'b00, 32'h40000000, 0);
        vecs[14] = mk(4'h1, 0, 0, 0, 0,            1, 0, 32'h80000002, 2'b00, 32'h60000000, 0);
        vecs[15] = mk(4'h1, 0, 0, 0, 0,            0, 1, 32'h80000002, 2'b00, 32'h50000000, 0);
        vecs[16] = mk(4'h0, 0, 0, 1, 32'hFFFFFFF8, 0, 0, 32'hFFFFFFF8, 2'b11, 32'h0, 0);
        vecs[17] = mk(4'h0, 0, 0, 0, 0,            0, 0, 32'h00000000, 2'b11, 32'h0, 0);
        vecs[18] = mk(4'h0, 0, 0, 0, 0,            0, 0, 32'h00000008, 2'b11, 32'h0, 0);
        vecs[19] = mk(4'h8, 0, 0, 1, 32'h80000010, 0, 0, 32'h00000008, 2'b11, 32'h0, 1);
        vecs[20] = mk(4'h8, 0, 0, 1, 32'h80000020, 0, 0, 32'h00000008, 2'b11, 32'h0, 1);
        vecs[21] = mk(4'h0, 0, 0, 0, 0,            0, 0, 32'h80000020, 2'b11, 32'h0, 0);
        vecs[22] = mk(4'h1, 0, 0, 1, 32'h80000030, 0, 0, 32'h80000020, 2'b11, 32'h0, 1);
        vecs[23] = mk(4'h0, 0, 0, 1, 32'h80000040, 0, 0, 32'h80000040, 2'b11, 32'h0, 0);
        vecs[24] = mk(4'h0, 1, 32'h00001000, 1, 32'h80000000, 0, 0, 32'h00001000, 2'b11, 32'h0, 0);
        vecs[25] = mk(4'h0, 0, 0, 1, 32'h80000005, 0, 0, 32'h80000005, 2'b00, 32'h40000000, 0);
        vecs[26] = mk(4'h0, 0, 0, 0, 0,            0, 0, 32'h80000008, 2'b11, 32'h0, 0);
        vecs[27] = mk(4'h0, 0, 0, 1, 32'h8000000C, 0, 0, 32'h8000000C, 2'b10, 32'h0, 0);
        vecs[28] = mk(4'h1, 1, 32'hBFC00200, 0, 0, 0, 0, 32'hBFC00200, 2'b11, 32'h0, 0);
        vecs[29] = mk(4'h1, 0, 0, 0, 0,            1, 1, 32'hBFC00200, 2'b11, 32'h30000000, 0);

        // Reset wins over simultaneous exception and branch requests.
        rst = 1'b1;
        drive(4'h0, 1, 32'h12345678, 1, 32'h87654320, 0, 0);
        drive(4'h0, 1, 32'h12345678, 1, 32'h87654320, 0, 0);
        chk("reset_pc", pc, 32'hBFC00000);
        chk("reset_pend", 32'(redirect_pending), 32'h0);
        chk("reset_valid", 32'(fetch_valid), 32'h3);
        chk("reset_etype", exception_type, 32'h0);
`ifdef PC_REDIRECT_CNT_EN
        chk("reset_br_cnt", br_cnt, 32'h0);
        chk("reset_exc_cnt", exc_cnt, 32'h0);
`endif
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].stall, vecs[i].exc, vecs[i].exc_pc, vecs[i].br, vecs[i].br_pc,
                  vecs[i].refill, vecs[i].invalid);
            chk($sformatf("vec%0d_pc", i), pc, vecs[i].e_pc);
            chk($sformatf("vec%0d_valid", i), 32'(fetch_valid), 32'(vecs[i].e_valid));
            chk($sformatf("vec%0d_etype", i), exception_type, vecs[i].e_etype);
            chk($sformatf("vec%0d_pend", i), 32'(redirect_pending), 32'(vecs[i].e_pend));
        end

        // Reset arriving mid-PEND drops the parked target; fetch restarts at the boot vector.
        drive(4'h2, 0, 0, 1, 32'h80005000, 0, 0);
        chk("pend_before_rst", 32'(redirect_pending), 32'h1);
        rst = 1'b1;
        drive(4'h2, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        chk("rst_mid_pend_pc", pc, 32'hBFC00000);
        chk("rst_mid_pend_flag", 32'(redirect_pending), 32'h0);
        drive(4'h0, 0, 0, 0, 0, 0, 0);
        chk("after_rst_seq_pc", pc, 32'hBFC00008);

`ifdef PC_REDIRECT_CNT_EN
        // Two branch loads (one direct, one via the buffer) and one exception.
        drive(4'h0, 0, 0, 1, 32'h80000000, 0, 0);
        drive(4'h1, 0, 0, 1, 32'h80000100, 0, 0);
        chk("cnt_pend_not_counted", br_cnt, 32'h1);
        drive(4'h0, 0, 0, 0, 0, 0, 0);
        chk("cnt_pend_load_pc", pc, 32'h80000100);
        drive(4'h0, 1, 32'hBFC00380, 0, 0, 0, 0);
        chk("br_redirect_cnt", br_cnt, 32'h2);
        chk("exc_redirect_cnt", exc_cnt, 32'h1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
